// File: rtl/icb_imem_sram_ctrl.sv
// Read-only ICB slave serving instruction fetches from a single-port synchronous SRAM.
// Up to two fetches in flight, in order; bad addresses get an error response.
module icb_imem_sram_ctrl #(
  parameter int unsigned IMEM_DEPTH   = 8192,
  parameter logic [31:0] TO_HOST_ADDR = 32'h3000,
  parameter int unsigned SIM_DELAY    = 1,
  localparam int unsigned AW          = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   s_icb_cmd_inst_addr,
  input  logic          s_icb_cmd_inst_valid,
  output logic          s_icb_cmd_inst_ready,
  output logic [31:0]   s_icb_rsp_inst_rdata,
  output logic          s_icb_rsp_inst_err,
  output logic          s_icb_rsp_inst_valid,
  input  logic          s_icb_rsp_inst_ready,
  output logic          bram_en,
  output logic [AW-1:0] bram_addr,
  input  logic [31:0]   bram_dout,
  output logic          tohost_hit,
  output logic          tohost_done,
  output logic [31:0]   fetch_cnt
);

  logic        unused_sim_delay;
  assign unused_sim_delay = (SIM_DELAY != 0);

  logic [1:0]  occ_q, occ_d;
  logic        slot_vld_q, slot_err_q;
  logic [31:0] buf_data_q [2];
  logic        buf_err_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic        tohost_hit_q, tohost_done_q;
  logic [31:0] fetch_cnt_q;

  logic        cmd_hs, rsp_hs, cmd_err, buf_empty, push, pop, hit;
  logic [31:0] slot_data;

  // Ready depends only on registered occupancy.
  assign s_icb_cmd_inst_ready = (occ_q != 2'd2);
  assign cmd_hs  = s_icb_cmd_inst_valid & s_icb_cmd_inst_ready;
  assign cmd_err = (s_icb_cmd_inst_addr[1:0] != 2'b00) ||
                   ({2'b00, s_icb_cmd_inst_addr[31:2]} >= IMEM_DEPTH);
  assign hit     = cmd_hs & (s_icb_cmd_inst_addr == TO_HOST_ADDR);

  assign bram_en   = cmd_hs & ~cmd_err;
  assign bram_addr = s_icb_cmd_inst_addr[AW+1:2];

  assign slot_data = slot_err_q ? 32'h0 : bram_dout;
  assign buf_empty = (buf_cnt_q == 2'd0);

  always_comb begin
    s_icb_rsp_inst_valid = ~buf_empty | slot_vld_q;
    s_icb_rsp_inst_rdata = 32'h0;
    s_icb_rsp_inst_err   = 1'b0;
    if (!buf_empty) begin
      s_icb_rsp_inst_rdata = buf_data_q[rd_ptr_q];
      s_icb_rsp_inst_err   = buf_err_q[rd_ptr_q];
    end else if (slot_vld_q) begin
      s_icb_rsp_inst_rdata = slot_data;
      s_icb_rsp_inst_err   = slot_err_q;
    end
  end

  assign rsp_hs = s_icb_rsp_inst_valid & s_icb_rsp_inst_ready;
  assign pop    = rsp_hs & ~buf_empty;
  // Slot data survives only by bypass; anything else lands in the buffer.
  assign push   = slot_vld_q & ~(buf_empty & s_icb_rsp_inst_ready);

  assign buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};
  assign occ_d     = occ_q + {1'b0, cmd_hs} - {1'b0, rsp_hs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q         <= 2'd0;
      slot_vld_q    <= 1'b0;
      slot_err_q    <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      buf_cnt_q     <= 2'd0;
      tohost_hit_q  <= 1'b0;
      tohost_done_q <= 1'b0;
      fetch_cnt_q   <= 32'h0;
    end else begin
      occ_q      <= occ_d;
      slot_vld_q <= cmd_hs;
      slot_err_q <= cmd_hs & cmd_err;
      buf_cnt_q  <= buf_cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      tohost_hit_q <= hit;
      if (hit) tohost_done_q <= 1'b1;
      if (cmd_hs) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  // Payload storage needs no reset; pointers and count gate its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= slot_data;
      buf_err_q[wr_ptr_q]  <= slot_err_q;
    end
  end

  assign tohost_hit  = tohost_hit_q;
  assign tohost_done = tohost_done_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_icb_imem_sram_ctrl.sv
// Directed bench for icb_imem_sram_ctrl with a behavioural SRAM whose word i is a known pattern.
module tb_icb_imem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_addr;
  logic        cmd_valid, cmd_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_valid, rsp_ready;
  logic        bram_en;
  logic [12:0] bram_addr;
  logic [31:0] bram_dout = 32'h0;
  logic        tohost_hit, tohost_done;
  logic [31:0] fetch_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int en_cnt  = 0;
  int en_base;

  always #5 clk = ~clk;

  icb_imem_sram_ctrl #(
    .IMEM_DEPTH  (8192),
    .TO_HOST_ADDR(32'h3000),
    .SIM_DELAY   (1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_icb_cmd_inst_addr (cmd_addr),
    .s_icb_cmd_inst_valid(cmd_valid),
    .s_icb_cmd_inst_ready(cmd_ready),
    .s_icb_rsp_inst_rdata(rsp_rdata),
    .s_icb_rsp_inst_err  (rsp_err),
    .s_icb_rsp_inst_valid(rsp_valid),
    .s_icb_rsp_inst_ready(rsp_ready),
    .bram_en             (bram_en),
    .bram_addr           (bram_addr),
    .bram_dout           (bram_dout),
    .tohost_hit          (tohost_hit),
    .tohost_done         (tohost_done),
    .fetch_cnt           (fetch_cnt)
  );

  function automatic logic [31:0] word_of(input logic [12:0] idx);
    return (idx == 13'd0) ? 32'h0000_0013 : {16'hC0DE, 3'b000, idx};
  endfunction

  always @(posedge clk) begin
    if (bram_en) begin
      bram_dout <= word_of(bram_addr);
      en_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Drive just after a rising edge, then move to the falling edge for sampling.
  task automatic cyc(input logic v, input logic [31:0] a, input logic rr);
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_addr  = a;
    rsp_ready = rr;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_bram_en"}, bram_en, 0);
    check({tag, "_hit"}, tohost_hit, 0);
    check({tag, "_done"}, tohost_done, 0);
    check({tag, "_fetch_cnt"}, fetch_cnt, 0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'h0; rsp_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_reset("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch of word 0
    cyc(1, 32'h0, 1);
    check("t1_bram_en", bram_en, 1);
    check("t1_bram_addr", bram_addr, 0);
    cyc(0, 32'h0, 1);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rdata", rsp_rdata, 32'h13);
    check("t1_err", rsp_err, 0);
    check("t1_fetch_cnt", fetch_cnt, 1);
    cyc(0, 32'h0, 1);
    check("t1_rsp_idle", rsp_valid, 0);

    // Back-to-back 0x0..0x3C
    for (int i = 0; i <= 16; i++) begin
      cyc(i < 16, 32'(i * 4), 1);
      if (i < 16) check("t2_cmd_ready", cmd_ready, 1);
      if (i > 0) begin
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rdata", rsp_rdata, word_of(13'(i - 1)));
      end
    end
    cyc(0, 32'h0, 1);
    check("t2_rsp_idle", rsp_valid, 0);
    check("t2_fetch_cnt", fetch_cnt, 17);

    // Backpressure: 0x8, 0xC accepted, 0x10 stalls
    cyc(1, 32'h8, 0);
    check("t3_ready0", cmd_ready, 1);
    check("t3_valid0", rsp_valid, 0);
    cyc(1, 32'hC, 0);
    check("t3_ready1", cmd_ready, 1);
    check("t3_valid1", rsp_valid, 1);
    check("t3_rdata1", rsp_rdata, word_of(13'd2));
    cyc(1, 32'h10, 0);
    check("t3_ready2", cmd_ready, 0);
    check("t3_rdata2", rsp_rdata, word_of(13'd2));
    check("t3_cnt2", fetch_cnt, 19);
    cyc(1, 32'h10, 0);
    check("t3_ready3", cmd_ready, 0);
    check("t3_valid3", rsp_valid, 1);
    check("t3_rdata3", rsp_rdata, word_of(13'd2));
    check("t3_err3", rsp_err, 0);
    cyc(1, 32'h10, 1);
    check("t3_ready4", cmd_ready, 0);
    check("t3_rdata4", rsp_rdata, word_of(13'd2));
    cyc(1, 32'h10, 1);
    check("t3_ready5", cmd_ready, 1);
    check("t3_rdata5", rsp_rdata, word_of(13'd3));
    cyc(0, 32'h0, 1);
    check("t3_valid6", rsp_valid, 1);
    check("t3_rdata6", rsp_rdata, word_of(13'd4));
    check("t3_cnt6", fetch_cnt, 20);
    cyc(0, 32'h0, 1);
    check("t3_idle", rsp_valid, 0);

    // Misaligned, out of range, last valid word, then a normal fetch
    en_base = en_cnt;
    cyc(1, 32'h2, 1);
    check("t4_en_mis", bram_en, 0);
    check("t4_ready", cmd_ready, 1);
    cyc(1, 32'h8000, 1);
    check("t4_en_oor", bram_en, 0);
    check("t4_valid_mis", rsp_valid, 1);
    check("t4_err_mis", rsp_err, 1);
    check("t4_rdata_mis", rsp_rdata, 0);
    cyc(1, 32'h7FFC, 1);
    check("t4_en_last", bram_en, 1);
    check("t4_addr_last", bram_addr, 32'h1FFF);
    check("t4_err_oor", rsp_err, 1);
    check("t4_rdata_oor", rsp_rdata, 0);
    cyc(1, 32'h4, 1);
    check("t4_err_last", rsp_err, 0);
    check("t4_rdata_last", rsp_rdata, word_of(13'h1FFF));
    cyc(0, 32'h0, 1);
    check("t4_valid_4", rsp_valid, 1);
    check("t4_err_4", rsp_err, 0);
    check("t4_rdata_4", rsp_rdata, word_of(13'd1));
    check("t4_en_count", 32'(en_cnt - en_base), 2);
    check("t4_fetch_cnt", fetch_cnt, 24);

    // To-host detection, twice
    cyc(1, 32'h3000, 1);
    check("t5_hit_pre", tohost_hit, 0);
    check("t5_done_pre", tohost_done, 0);
    cyc(0, 32'h0, 1);
    check("t5_hit1", tohost_hit, 1);
    check("t5_done1", tohost_done, 1);
    check("t5_rdata1", rsp_rdata, word_of(13'hC00));
    cyc(0, 32'h0, 1);
    check("t5_hit1_end", tohost_hit, 0);
    check("t5_done_hold", tohost_done, 1);
    cyc(1, 32'h3000, 1);
    check("t5_hit_pre2", tohost_hit, 0);
    cyc(0, 32'h0, 1);
    check("t5_hit2", tohost_hit, 1);
    cyc(0, 32'h0, 1);
    check("t5_hit2_end", tohost_hit, 0);
    check("t5_done2", tohost_done, 1);
    check("t5_fetch_cnt", fetch_cnt, 26);

    // Reset while full
    cyc(1, 32'h20, 0);
    cyc(1, 32'h24, 0);
    cyc(0, 32'h0, 0);
    check("t6_full_ready", cmd_ready, 0);
    check("t6_full_rdata", rsp_rdata, word_of(13'd8));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset("t6_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 32'h0, 1);
    check("t6_bram_en", bram_en, 1);
    check("t6_valid_pre", rsp_valid, 0);
    cyc(0, 32'h0, 1);
    check("t6_valid", rsp_valid, 1);
    check("t6_rdata", rsp_rdata, 32'h13);
    check("t6_fetch_cnt", fetch_cnt, 1);
    cyc(0, 32'h0, 1);
    check("t6_idle", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icb_imem_sram_ctrl.md
# icb_imem_sram_ctrl

Read-only ICB slave that serves the core's instruction-fetch bus (`m_icb_cmd_inst_*` of the CPU) from a single-port synchronous instruction SRAM. It sits directly downstream of the core's instruction bus inside the simulation top.

Features:
- Up to 2 outstanding fetches, in order.
- Misaligned and out-of-range addresses are answered with an error response.
- A to-host fetch detector gives benches and the top a registered end-of-test indication.

## Interface
Parameters:
- IMEM_DEPTH, 8192: SRAM depth in 32-bit words. Power of 2, at least 2.
- TO_HOST_ADDR, 32'h3000: byte address whose accepted fetch marks end of test.
- SIM_DELAY, 1: simulation delay on register updates. No functional effect.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_icb_cmd_inst_addr  in  32  fetch byte address.
- s_icb_cmd_inst_valid  in  1  command valid.
- s_icb_cmd_inst_ready  out  1  command ready.
- s_icb_rsp_inst_rdata  out  32  instruction word.
- s_icb_rsp_inst_err  out  1  error response.
- s_icb_rsp_inst_valid  out  1  response valid.
- s_icb_rsp_inst_ready  in  1  response ready.
- bram_en  out  1  SRAM read enable.
- bram_addr  out  clog2(IMEM_DEPTH)  SRAM word address.
- bram_dout  in  32  SRAM read data, valid exactly 1 cycle after bram_en.
- tohost_hit  out  1  1-cycle pulse, one cycle after a to-host command handshake.
- tohost_done  out  1  sticky flag, set together with the first tohost_hit.
- fetch_cnt  out  32  count of accepted commands, wraps at 2^32.

## Operation
**Command acceptance**
- A command is accepted when `cmd_valid & cmd_ready`.
- `occ` = responses accepted but not yet delivered: in-flight slot plus buffer entries, range 0..2.
- `cmd_ready = (occ < 2)`. It depends only on registered state, never on `cmd_valid` or `rsp_ready`.

**Error check**
- err = `addr[1:0] != 0` OR `addr[31:2] >= IMEM_DEPTH`.
- On error, `bram_en` stays low and the response carries rdata=0, err=1.

**SRAM access**
- On an accepted, non-error command: `bram_en=1`, `bram_addr=addr[clog2(IMEM_DEPTH)+1:2]`, combinational in the handshake cycle.

**In-flight slot**
- Registered valid + err bit, loaded on every accepted command.
- The slot's data is `bram_dout` (or 0 if err) in the cycle after acceptance.

**Response buffer**
- 2-entry FIFO of {rdata, err}.
- Response source: buffer head if the buffer is non-empty; else the in-flight slot (bypass).
- In-flight data that is not consumed in its cycle is pushed into the buffer. This includes arrival while the buffer is non-empty.
- The slot is cleared when not reloaded.
- Responses are strictly in command order.

**occ update**
- `occ_next = occ + (cmd handshake) - (rsp handshake)`.
- Command and response handshakes in the same cycle leave `occ` unchanged.

**To-host tracking**
- An accepted command with `addr == TO_HOST_ADDR` sets a registered `tohost_hit` for exactly 1 cycle and sets `tohost_done`.
- `tohost_done` stays set until rst. Repeat hits pulse again.
- The command is served normally, including error checking.
- `fetch_cnt` increments on every accepted command.

**Reset (asynchronous)**
- Clears occ, in-flight slot, buffer pointers, tohost_hit, tohost_done, fetch_cnt.
- Outstanding responses are discarded.

## Timing
**Reset values of outputs**
- cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- bram_en=0, tohost_hit=0, tohost_done=0, fetch_cnt=0.

**Latency and throughput**
- Command handshake at cycle t gives rsp_valid at t+1 (bypass path), when the buffer is empty.
- With `rsp_ready` held high, sustained throughput is 1 fetch/cycle: steady state occ=1, cmd_ready=1.

**Backpressure**
- With `rsp_ready` low, at most 2 commands are accepted. cmd_ready drops in the cycle after occ reaches 2.
- rsp_valid/rdata/err remain stable while `rsp_valid & ~rsp_ready`.

**Simultaneous events**
- In-flight data arriving while the buffer head is consumed, with the buffer holding 1 entry: the head pops and the new data pushes in the same cycle.
- Occupancy never exceeds 2, so no overflow.

**Boundaries**
- addr = (IMEM_DEPTH-1)*4 is valid.
- addr = IMEM_DEPTH*4 returns err=1.
- fetch_cnt wraps from 0xFFFFFFFF to 0.

## Test plan
- Reset, SRAM word[0]=0x00000013; fetch 0x0 with rsp_ready=1 -> rsp_valid at t+1, rdata=0x00000013, err=0, fetch_cnt=1.
- Back-to-back fetches 0x0,0x4,...,0x3C with rsp_ready=1 -> 16 responses on consecutive cycles, in order, cmd_ready never low.
- rsp_ready=0, issue 3 commands (0x8,0xC,0x10) -> 2 accepted, cmd_ready=0, 3rd stalls; raise rsp_ready -> responses 0x8,0xC,0x10 data, in order, no loss.
- Fetch 0x2 and 0x8000 (IMEM_DEPTH=8192) -> both err=1, rdata=0, bram_en never asserted; a following fetch 0x4 returns normal data in order.
- Fetch 0x3000 twice -> tohost_hit pulses 1 cycle after each handshake, tohost_done=1 from the first pulse onward.
- Assert rst with occ=2 mid-stream -> all outputs at reset values immediately; after release, fetch 0x0 returns only its own data, no stale response.
